// File: rtl/branch_predictor_pht.sv
// rtl/branch_predictor_pht.sv - PHT branch direction predictor with mispredict flag and statistics
//
// Pattern history table of saturating counters indexed by PC[INDEX_BITS+1:2].
// The IF stage reads a combinational prediction. The EX stage trains the table and
// raises a registered one-cycle miss that requests a pipeline flush.
//
// Optional feature macro: PHT_BYPASS_EN
//   defined   - a same-cycle update to the looked-up index is forwarded to prediction
//   undefined - prediction always shows the stored (pre-update) counter
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   pred_pc        in   IF-stage PC to predict
//   prediction     out  predicted direction for pred_pc (1 = taken), combinational
//   res_valid      in   EX stage resolves a conditional branch this cycle
//   res_pc         in   PC of the resolving branch
//   outcome        in   actual direction (1 = taken)
//   res_prediction in   prediction issued for this branch at IF
//   miss           out  registered mispredict flag
//   stat_clr       in   synchronous clear of the statistics counters
//   branch_count   out  resolved branches since reset/clear (saturating)
//   miss_count     out  mispredicts since reset/clear (saturating)

module branch_predictor_pht #(
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int PC_BITS    = 32,
    parameter int STAT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_BITS-1:0]   pred_pc,
    output logic                 prediction,
    input  logic                 res_valid,
    input  logic [PC_BITS-1:0]   res_pc,
    input  logic                 outcome,
    input  logic                 res_prediction,
    output logic                 miss,
    input  logic                 stat_clr,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] miss_count
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]  CTR_ZERO = '0;
    // Weakly not-taken: MSB clear, every lower bit set.
    localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    logic [CTR_BITS-1:0]   pht [DEPTH];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   pred_stored;
    logic [CTR_BITS-1:0]   upd_cur;
    logic [CTR_BITS-1:0]   upd_next;
    logic                  mispredict;

    // Word-aligned PCs: the two low bits and everything above the index are ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[PC_BITS-1:INDEX_BITS+2], pred_pc[1:0],
                              res_pc[PC_BITS-1:INDEX_BITS+2], res_pc[1:0]};

    assign pred_idx    = pred_pc[INDEX_BITS+1:2];
    assign upd_idx     = res_pc[INDEX_BITS+1:2];
    assign pred_stored = pht[pred_idx];
    assign upd_cur     = pht[upd_idx];
    assign mispredict  = res_valid & (outcome ^ res_prediction);

    always_comb begin
        upd_next = upd_cur;
        if (outcome) begin
            if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_BITS'(1);
        end else begin
            if (upd_cur != CTR_ZERO) upd_next = upd_cur - CTR_BITS'(1);
        end
    end

`ifdef PHT_BYPASS_EN
    // Write-through forward of the counter being trained this cycle.
    assign prediction = (res_valid && (pred_idx == upd_idx)) ? upd_next[CTR_BITS-1]
                                                             : pred_stored[CTR_BITS-1];
`else
    assign prediction = pred_stored[CTR_BITS-1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (res_valid) begin
            pht[upd_idx] <= upd_next;
        end
    end

    // Miss compares against the prediction issued at IF, not the live table, so an
    // intervening retrain of the same entry cannot hide a mispredict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss <= 1'b0;
        end else begin
            miss <= mispredict;
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count <= '0;
            miss_count   <= '0;
        end else if (stat_clr) begin
            branch_count <= '0;
            miss_count   <= '0;
        end else begin
            if (res_valid && (branch_count != STAT_MAX)) begin
                branch_count <= branch_count + STAT_BITS'(1);
            end
            if (mispredict && (miss_count != STAT_MAX)) begin
                miss_count <= miss_count + STAT_BITS'(1);
            end
        end
    end

endmodule
